// File: rtl/half_adder_pkg.sv
// Shared constants for the registered half-adder bank.
package half_adder_pkg;

  localparam logic RST_VAL = 1'b0;

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder: sum = a ^ b, carry = a & b.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Bank of WIDTH independent half-adder lanes with one registered output stage.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;
  logic [WIDTH-1:0] sum_p0;
  logic [WIDTH-1:0] carry_p0;
  logic             vld_p0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum_c[i]),
      .carry (carry_c[i])
    );
  end

  // Stage p0: results load only on in_valid so X on idle inputs never reaches the hold value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p0   <= {WIDTH{RST_VAL}};
      carry_p0 <= {WIDTH{RST_VAL}};
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        sum_p0   <= sum_c;
        carry_p0 <= carry_c;
      end
    end
  end

  assign sum       = sum_p0;
  assign carry     = carry_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_half_adder.sv
// Directed and randomized checks of half_adder at WIDTH=1 and WIDTH=4.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [0:0] a1, b1, sum1, carry1;
  logic [3:0] a4, b4, sum4, carry4;
  logic       ov1, ov4;
  int         total = 0;
  int         bad = 0;

  logic [0:0] e_s1, e_c1;
  logic [3:0] e_s4, e_c4;
  logic       e_v;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .sum(sum1), .carry(carry1), .out_valid(ov1)
  );

  half_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .sum(sum4), .carry(carry4), .out_valid(ov4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic s, input logic c, input logic v);
    chk({tag, "_sum"}, {3'b0, sum1}, {3'b0, s});
    chk({tag, "_carry"}, {3'b0, carry1}, {3'b0, c});
    chk({tag, "_vld"}, {3'b0, ov1}, {3'b0, v});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;

    // Reset held with valid inputs present: outputs stay cleared.
    for (int i = 0; i < 2; i++) begin
      step();
      chk1("reset", 1'b0, 1'b0, 1'b0);
      chk("reset_sum4", sum4, 4'h0);
      chk("reset_carry4", carry4, 4'h0);
      chk("reset_vld4", {3'b0, ov4}, 4'h0);
    end

    // Exhaustive truth table, back to back.
    rst = 1'b0; a4 = 4'h0; b4 = 4'h0;
    a1 = 1'b0; b1 = 1'b0; step(); chk1("tt00", 1'b0, 1'b0, 1'b1);
    a1 = 1'b0; b1 = 1'b1; step(); chk1("tt01", 1'b1, 1'b0, 1'b1);
    a1 = 1'b1; b1 = 1'b0; step(); chk1("tt10", 1'b1, 1'b0, 1'b1);
    a1 = 1'b1; b1 = 1'b1; step(); chk1("tt11", 1'b0, 1'b1, 1'b1);

    // Hold: idle cycle with changed inputs keeps last result.
    in_valid = 1'b0; a1 = 1'b0; b1 = 1'b1; step(); chk1("hold", 1'b0, 1'b1, 1'b0);
    a1 = 1'bx; b1 = 1'bx; step(); chk1("hold_x", 1'b0, 1'b1, 1'b0);

    // Lane independence on the 4-lane bank.
    in_valid = 1'b1; a1 = 1'b0; b1 = 1'b0; a4 = 4'b1100; b4 = 4'b1010; step();
    chk("lane_sum4", sum4, 4'b0110);
    chk("lane_carry4", carry4, 4'b1000);
    chk("lane_vld4", {3'b0, ov4}, 4'h1);
    a4 = 4'b1111; b4 = 4'b0101; step();
    chk("lane2_sum4", sum4, 4'b1010);
    chk("lane2_carry4", carry4, 4'b0101);

    // Reset mid-stream discards the sample taken with it.
    rst = 1'b1; a1 = 1'b1; b1 = 1'b0; step(); chk1("mid_rst", 1'b0, 1'b0, 1'b0);
    chk("mid_rst_sum4", sum4, 4'h0);
    rst = 1'b0; step(); chk1("after_rst", 1'b1, 1'b0, 1'b1);

    // Random traffic against a one-cycle-delayed reference model.
    e_s1 = sum1; e_c1 = carry1; e_s4 = sum4; e_c4 = carry4;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a1 = 1'($urandom); b1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      if (in_valid) begin
        e_s1 = a1 ^ b1; e_c1 = a1 & b1;
        e_s4 = a4 ^ b4; e_c4 = a4 & b4;
      end
      e_v = in_valid;
      step();
      chk("rnd_inv1", {3'b0, sum1 & carry1}, 4'h0);
      chk("rnd_inv4", sum4 & carry4, 4'h0);
      chk("rnd_sum1", {3'b0, sum1}, {3'b0, e_s1});
      chk("rnd_carry1", {3'b0, carry1}, {3'b0, e_c1});
      chk("rnd_sum4", sum4, e_s4);
      chk("rnd_carry4", carry4, e_c4);
      chk("rnd_vld1", {3'b0, ov1}, {3'b0, e_v});
      chk("rnd_vld4", {3'b0, ov4}, {3'b0, e_v});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Registered bank of WIDTH independent 1-bit half adders.
- Each bit lane computes sum = a XOR b and carry = a AND b.
- Results are captured in output registers one clock after the inputs are presented.
- Used as a leaf arithmetic primitive in the datapath. The default WIDTH=1 gives the classic single-bit half adder truth table.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (bit i of a/b feeds lane i only; lanes do not chain).

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a/b this cycle.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- sum  output  WIDTH  registered per-lane sum bit (a[i] ^ b[i]).
- carry  output  WIDTH  registered per-lane carry-out (a[i] & b[i]).
- out_valid  output  1  high for one cycle when sum/carry hold a new result.

Behaviour:
- The interface has one clock and one reset. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: sum = 0, carry = 0, out_valid = 0. Reset overrides in_valid in the same cycle.
- Combinational core, per lane i:
  - s[i] = a[i] ^ b[i]
  - c[i] = a[i] & b[i]
  - No carry propagates between lanes.
- Latency is exactly 1 cycle. If in_valid is high at edge N (rst low), then after edge N:
  - sum and carry hold f(a,b) sampled at edge N.
  - out_valid = 1.
- If in_valid is low at an edge (rst low):
  - out_valid becomes 0.
  - sum and carry hold their previous values.
- Throughput: one result per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- There is no backpressure and no ready signal; consumers must accept each result in its valid cycle.
- Truth table, per lane:
  - 0+0 -> sum 0, carry 0
  - 0+1 -> sum 1, carry 0
  - 1+0 -> sum 1, carry 0
  - 1+1 -> sum 0, carry 1
- Invariant: sum[i] & carry[i] is never 1.
- Reset mid-stream: a result sampled in the same cycle as rst is discarded. The next in_valid after rst deasserts is processed normally.
- X on a/b while in_valid is low must not corrupt the held sum/carry.

Decomposition:
- Shared package: no typedefs needed. Optionally a localparam holding the reset value for the output registers.
- Sub-module half_adder_cell: purely combinational, 1-bit (a, b -> sum, carry).
  - Instantiated WIDTH times in a generate loop.
  - The parent holds only the valid/output registers.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=1, b=1 -> sum=0, carry=0, out_valid=0 throughout.
- WIDTH=1 exhaustive: apply (0,0), (0,1), (1,0), (1,1) on consecutive cycles with in_valid=1 -> one cycle later sum/carry = 0/0, 1/0, 1/0, 0/1, with out_valid high on all four cycles.
- Hold: apply a=1, b=1 valid, then in_valid=0 with a=0, b=1 -> sum=0, carry=1 retained and out_valid=0.
- Lane independence, WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000 after 1 cycle.
- Reset mid-stream: valid a=1, b=0 in the same cycle rst=1 -> next cycle sum=0, out_valid=0. The following cycle with valid a=1, b=0 and rst=0 gives sum=1 one cycle later.
- Invariant check: random a/b for 1000 cycles -> (sum & carry)==0 every cycle, and outputs match the reference model delayed by 1 cycle.
